// File: rtl/dfa_bit_serializer.sv
// dfa_bit_serializer
//   Feeds the serial-input DFA recognisers. It takes parallel words of variable
//   length over a valid/ready handshake and shifts them out one bit per clock,
//   MSB first. Frame start and frame end are marked so the downstream checker
//   knows when to sample accept.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   in_valid     upstream word valid
//   in_ready     word accepted this cycle (combinational)
//   in_data      word; bits [in_len-1:0] are sent, bit in_len-1 first
//   in_len       bits to send, legal 1..WIDTH
//   en           shift enable; 0 pauses the shifter
//   bit_out      serial bit to the DFA
//   bit_valid    bit_out carries a live frame bit
//   frame_start  first bit of a frame
//   frame_last   last bit of a frame
//   len_err      one-cycle pulse: a word with an illegal length was dropped
//   busy         a frame is in progress
module dfa_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic             len_err,
    output logic             busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] flen, flen_n;     // length of the frame being sent
    logic             bo_n, bv_n, fs_n, fl_n, le_n;

    logic             xfer;
    logic             len_ok;
    logic [WIDTH-1:0] shifted;

    // Accepting on the last-bit edge of a frame keeps back-to-back frames gapless.
    assign in_ready = rst && ((state == IDLE) ||
                              (state == SHIFT && en && cnt == LEN_W'(1)));
    assign xfer     = in_valid && in_ready;
    assign len_ok   = (in_len != '0) && (in_len <= LEN_W'(WIDTH));
    assign busy     = (state == SHIFT);

    // Current bit sreg[cnt-1] brought down to bit 0.
    assign shifted  = sreg >> (cnt - 1'b1);

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        flen_n  = flen;
        bo_n    = bit_out;       // bit_out holds whenever no bit is sent
        bv_n    = 1'b0;
        fs_n    = 1'b0;
        fl_n    = 1'b0;
        le_n    = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    if (len_ok) begin
                        state_n = SHIFT;
                        sreg_n  = in_data;
                        cnt_n   = in_len;
                        flen_n  = in_len;
                    end else begin
                        le_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (en) begin
                    bo_n  = shifted[0];
                    bv_n  = 1'b1;
                    fs_n  = (cnt == flen);
                    fl_n  = (cnt == LEN_W'(1));
                    cnt_n = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        // Last bit: reload on a legal word, otherwise fall back to IDLE.
                        state_n = IDLE;
                        if (xfer) begin
                            if (len_ok) begin
                                state_n = SHIFT;
                                sreg_n  = in_data;
                                cnt_n   = in_len;
                                flen_n  = in_len;
                            end else begin
                                le_n = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            flen        <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            state       <= state_n;
            sreg        <= sreg_n;
            cnt         <= cnt_n;
            flen        <= flen_n;
            bit_out     <= bo_n;
            bit_valid   <= bv_n;
            frame_start <= fs_n;
            frame_last  <= fl_n;
            len_err     <= le_n;
        end
    end

endmodule

// File: tb/tb_dfa_bit_serializer.sv
// Bench for dfa_bit_serializer: vector table, directed multi-cycle sequences and
// randomized traffic, all checked against a queue-based frame model.
module tb_dfa_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [3:0] in_len = '0;
    logic       en = 1'b0;
    logic       bit_out, bit_valid, frame_start, frame_last, len_err, busy;

    dfa_bit_serializer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .en(en), .bit_out(bit_out),
        .bit_valid(bit_valid), .frame_start(frame_start), .frame_last(frame_last),
        .len_err(len_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: the remaining bits of the current frame, in send order.
    bit q[$];
    bit m_bo = 0, m_bv = 0, m_fs = 0, m_fl = 0, m_le = 0, m_first = 0;
    bit rdy_s;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bit_valid, bit_out, frame_start, frame_last, len_err, busy};
    endfunction

    task automatic model_edge(input bit xf);
        if (!rst) begin
            q.delete();
            m_bo = 0; m_bv = 0; m_fs = 0; m_fl = 0; m_le = 0; m_first = 0;
        end else begin
            m_le = 0;
            if (q.size() > 0 && en) begin
                m_bo = q.pop_front();
                m_bv = 1;
                m_fs = m_first;
                m_first = 0;
                m_fl = (q.size() == 0);
            end else begin
                m_bv = 0; m_fs = 0; m_fl = 0;
            end
            if (xf) begin
                if (in_len >= 1 && in_len <= 8) begin
                    q.delete();
                    for (int i = int'(in_len) - 1; i >= 0; i--) q.push_back(in_data[i]);
                    m_first = 1;
                end else begin
                    m_le = 1;
                end
            end
        end
    endtask

    // One clock: check in_ready mid-cycle, take the edge, check registered outputs.
    task automatic step(output bit xf);
        bit m_rdy;
        @(negedge clk);
        m_rdy = rst && (q.size() == 0 || (en && q.size() == 1));
        rdy_s = in_ready;
        chk("model_ready", 16'(in_ready), 16'(m_rdy));
        xf = in_valid && m_rdy;
        @(posedge clk);
        model_edge(xf);
        #1;
        chk("model_outs", 16'(outs()), 16'({m_bv, m_bo, m_fs, m_fl, m_le, q.size() > 0}));
    endtask

    typedef struct {
        bit         rst;
        bit         vld;
        logic [7:0] data;
        logic [3:0] len;
        bit         en;
        bit         rdy;
        logic [5:0] out;   // {bit_valid, bit_out, frame_start, frame_last, len_err, busy}
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit xf;
        int nb, nx, first, lastc, gaps, pause;
        bit saw_last;
        logic [15:0] bits, rdys;

        tbl[0]  = '{0, 0, 8'h00, 4'd0, 0, 0, 6'b000000};
        tbl[1]  = '{0, 0, 8'h00, 4'd0, 0, 0, 6'b000000};
        tbl[2]  = '{1, 1, 8'h0C, 4'd4, 1, 1, 6'b000001};
        tbl[3]  = '{1, 0, 8'h00, 4'd0, 1, 0, 6'b111001};
        tbl[4]  = '{1, 0, 8'h00, 4'd0, 1, 0, 6'b110001};
        tbl[5]  = '{1, 0, 8'h00, 4'd0, 1, 0, 6'b100001};
        tbl[6]  = '{1, 0, 8'h00, 4'd0, 1, 1, 6'b100100};
        tbl[7]  = '{1, 0, 8'h00, 4'd0, 1, 1, 6'b000000};
        tbl[8]  = '{1, 1, 8'hFF, 4'd0, 1, 1, 6'b000010};
        tbl[9]  = '{1, 1, 8'hFF, 4'd9, 1, 1, 6'b000010};
        tbl[10] = '{1, 1, 8'h03, 4'd2, 1, 1, 6'b000001};
        tbl[11] = '{1, 0, 8'h00, 4'd0, 1, 0, 6'b111001};
        tbl[12] = '{1, 0, 8'h00, 4'd0, 1, 1, 6'b110100};
        tbl[13] = '{1, 0, 8'h00, 4'd0, 1, 1, 6'b010000};

        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].data;
            in_len = tbl[i].len; en = tbl[i].en;
            step(xf);
            chk($sformatf("tbl%0d_ready", i), 16'(rdy_s), 16'(tbl[i].rdy));
            chk($sformatf("tbl%0d_outs", i), 16'(outs()), 16'(tbl[i].out));
        end

        // Back-to-back frames 1011 then 100 with in_valid held.
        in_valid = 1; in_data = 8'h0B; in_len = 4; en = 1;
        nb = 0; nx = 0; first = -1; lastc = -1; bits = '0; rdys = '0;
        for (int c = 0; c < 20 && nb < 7; c++) begin
            step(xf);
            if (xf) begin
                nx++;
                if (nx == 1) begin in_data = 8'h04; in_len = 3; end
                else in_valid = 0;
            end
            if (bit_valid) begin
                bits = {bits[14:0], bit_out};
                rdys = {rdys[14:0], rdy_s};
                if (first < 0) first = c;
                lastc = c;
                nb++;
            end
        end
        in_valid = 0;
        chk("b2b_count", 16'(nb), 16'd7);
        chk("b2b_bits", bits, 16'b1011100);
        chk("b2b_ready", rdys, 16'b0001001);
        chk("b2b_contig", 16'(lastc - first), 16'd6);

        // Pause of three cycles mid-frame.
        in_valid = 1; in_data = 8'hA5; in_len = 8; en = 1;
        step(xf);
        in_valid = 0;
        nb = 0; gaps = 0; pause = 0; bits = '0;
        for (int c = 0; c < 30 && nb < 8; c++) begin
            en = (nb == 3 && pause < 3) ? 1'b0 : 1'b1;
            if (!en) pause++;
            step(xf);
            if (bit_valid) begin
                bits = {bits[14:0], bit_out};
                nb++;
            end else if (nb > 0) begin
                gaps++;
            end
        end
        en = 1;
        chk("pause_bits", bits, 16'hA5);
        chk("pause_gaps", 16'(gaps), 16'd3);

        // Reset during bit 3 of a len-6 frame.
        in_valid = 1; in_data = 8'h2D; in_len = 6;
        step(xf);
        in_valid = 0;
        nb = 0; saw_last = 0;
        for (int c = 0; c < 10 && nb < 3; c++) begin
            step(xf);
            if (bit_valid) nb++;
            if (frame_last) saw_last = 1;
        end
        chk("rst_reached_bit3", 16'(nb), 16'd3);
        rst = 0;
        step(xf);
        chk("rst_ready", 16'(rdy_s), 16'd0);
        chk("rst_outs", 16'(outs()), 16'd0);
        chk("rst_no_last", 16'(saw_last), 16'd0);
        rst = 1;
        step(xf);
        chk("rst_release_ready", 16'(rdy_s), 16'd1);
        in_valid = 1; in_data = 8'h06; in_len = 3;
        step(xf);
        in_valid = 0;
        nb = 0; bits = '0;
        for (int c = 0; c < 10 && nb < 3; c++) begin
            step(xf);
            if (bit_valid) begin
                if (nb == 0) chk("rst_new_start", 16'(frame_start), 16'd1);
                bits = {bits[14:0], bit_out};
                nb++;
            end
        end
        chk("rst_new_bits", bits, 16'b110);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rst      = ($urandom_range(0, 59) != 0);
            in_valid = $urandom_range(0, 1);
            in_data  = 8'($urandom);
            in_len   = 4'($urandom_range(0, 10));
            en       = ($urandom_range(0, 3) != 0);
            step(xf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
